// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and sizing helpers for the FIFO read-side drain engine.
package fifo_rd_stream_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Skid buffer holds RD_LAT words in flight plus two so the pop rule sustains 1 word/clk.
    function automatic int unsigned buf_depth(input int unsigned rd_lat);
        return rd_lat + 2;
    endfunction

    localparam int unsigned RD_LAT_MAX    = 2;
    localparam int unsigned BUF_DEPTH_MAX = buf_depth(RD_LAT_MAX);
    localparam int unsigned PTR_W         = $clog2(BUF_DEPTH_MAX);
    localparam int unsigned OCC_W         = $clog2(BUF_DEPTH_MAX + RD_LAT_MAX + 1);

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular buffer absorbing FIFO read latency; head/tail wrap modulo DEPTH,
// occupancy tracked separately so full and empty are distinguishable.
module fifo_rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [OCC_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [OCC_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            // Clearing only rewinds bookkeeping; stale data is unreachable once count is 0.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= wdata_i;
                tail_q        <= wrap_inc(tail_q);
            end
            if (pop_i) begin
                head_q <= wrap_inc(head_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Reader-domain drain engine: pops a dual-clock FIFO into a valid/ready stream and
// supports a discard flush. Define FIFO_RD_STREAM_STATS_EN for transfer/stall/starve counters.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             fifo_rd_en_o,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    input  logic             fifo_empty_i,
    input  logic             fifo_underflow_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             flush_done_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             err_o
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_words_o,
    output logic [CNT_W-1:0] stat_stall_o,
    output logic [CNT_W-1:0] stat_starve_o
`endif
);

    localparam int unsigned BUF_DEPTH = buf_depth(RD_LAT);

    state_e            state_q;
    logic [RD_LAT-1:0] vld_q;
    logic [OCC_W-1:0]  count;
    logic [OCC_W-1:0]  inflight_c;
    logic [OCC_W-1:0]  entry_drop_c;
    logic              arrive_c;
    logic              xfer_c;
    logic              flush_go_c;
    logic              push_c;

    // Returns still travelling through the FIFO read pipeline.
    always_comb begin
        inflight_c = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight_c = inflight_c + OCC_W'(vld_q[i]);
        end
    end

    assign arrive_c   = vld_q[RD_LAT-1];
    assign flush_go_c = (state_q == RUN) && flush_i;
    assign push_c     = arrive_c && (state_q == RUN) && !flush_go_c;
    assign xfer_c     = m_valid_o && m_ready_i;

    // Pop only when every popped word is guaranteed a buffer slot; no path from m_ready_i.
    assign fifo_rd_en_o = !rst_i && !fifo_empty_i && ((count + inflight_c) < OCC_W'(BUF_DEPTH));

    assign m_valid_o = (count != '0) && (state_q == RUN);
    assign busy_o    = (state_q == FLUSH) || (count != '0) || (inflight_c != '0);

    // Words thrown away at flush entry: what stays buffered plus a word landing this cycle.
    assign entry_drop_c = count - OCC_W'(xfer_c) + OCC_W'(arrive_c);

    fifo_rd_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_go_c),
        .push_i  (push_c),
        .wdata_i (fifo_rdata_i),
        .pop_i   (xfer_c),
        .rdata_o (m_data_o),
        .count_o (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            vld_q        <= '0;
            drop_cnt_o   <= '0;
            flush_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            vld_q        <= (vld_q << 1) | RD_LAT'(fifo_rd_en_o);
            err_o        <= err_o | fifo_underflow_i;
            flush_done_o <= 1'b0;
            case (state_q)
                RUN: begin
                    if (flush_i) begin
                        state_q    <= FLUSH;
                        drop_cnt_o <= CNT_W'(entry_drop_c);
                    end
                end
                FLUSH: begin
                    if (arrive_c && (drop_cnt_o != '1)) begin
                        drop_cnt_o <= drop_cnt_o + CNT_W'(1);
                    end
                    // Empty already reflects every earlier pop, so nothing more can arrive.
                    if (fifo_empty_i && (inflight_c == '0)) begin
                        state_q      <= RUN;
                        flush_done_o <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Free-running wrap-around counters, restarted by reset and each completed flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_done_o) begin
            stat_words_o  <= '0;
            stat_stall_o  <= '0;
            stat_starve_o <= '0;
        end else begin
            if (xfer_c) begin
                stat_words_o <= stat_words_o + CNT_W'(1);
            end
            if (m_valid_o && !m_ready_i) begin
                stat_stall_o <= stat_stall_o + CNT_W'(1);
            end
            if ((state_q == RUN) && (count == '0) && m_ready_i) begin
                stat_starve_o <= stat_starve_o + CNT_W'(1);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: RD_LAT=1 and RD_LAT=2 instances, each behind a behavioural FIFO.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en   [2];
    logic [15:0] rdata   [2];
    logic        empty   [2];
    logic        uf      [2];
    logic        m_valid [2];
    logic [15:0] m_data  [2];
    logic        m_ready [2];
    logic        flush   [2];
    logic        busy    [2];
    logic        done    [2];
    logic [31:0] drop    [2];
    logic        err     [2];
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] st_words [2];
    logic [31:0] st_stall [2];
    logic [31:0] st_starve[2];
`endif

    int total;
    int bad;

    always #5 clk = ~clk;

    fifo_rd_stream #(.WIDTH(16), .RD_LAT(1), .CNT_W(32)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .fifo_rd_en_o(rd_en[0]), .fifo_rdata_i(rdata[0]),
        .fifo_empty_i(empty[0]), .fifo_underflow_i(uf[0]), .m_valid_o(m_valid[0]),
        .m_data_o(m_data[0]), .m_ready_i(m_ready[0]), .flush_i(flush[0]), .busy_o(busy[0]),
        .flush_done_o(done[0]), .drop_cnt_o(drop[0]), .err_o(err[0])
`ifdef FIFO_RD_STREAM_STATS_EN
        , .stat_words_o(st_words[0]), .stat_stall_o(st_stall[0]), .stat_starve_o(st_starve[0])
`endif
    );

    fifo_rd_stream #(.WIDTH(16), .RD_LAT(2), .CNT_W(32)) u_lat2 (
        .clk_i(clk), .rst_i(rst), .fifo_rd_en_o(rd_en[1]), .fifo_rdata_i(rdata[1]),
        .fifo_empty_i(empty[1]), .fifo_underflow_i(uf[1]), .m_valid_o(m_valid[1]),
        .m_data_o(m_data[1]), .m_ready_i(m_ready[1]), .flush_i(flush[1]), .busy_o(busy[1]),
        .flush_done_o(done[1]), .drop_cnt_o(drop[1]), .err_o(err[1])
`ifdef FIFO_RD_STREAM_STATS_EN
        , .stat_words_o(st_words[1]), .stat_stall_o(st_stall[1]), .stat_starve_o(st_starve[1])
`endif
    );

    // Behavioural dual-clock FIFO read port: an array of written words plus read/write indices.
    logic [15:0] fmem [2][512];
    int          fwr [2] = '{0, 0};
    int          frd [2] = '{0, 0};
    logic [15:0] stg [2];
    logic [15:0] stg2;

    always_comb begin
        for (int i = 0; i < 2; i++) empty[i] = (fwr[i] == frd[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i] === 1'b1 && fwr[i] != frd[i]) begin
                stg[i] <= fmem[i][frd[i]];
                frd[i] <= frd[i] + 1;
            end else begin
                stg[i] <= 16'hDEAD;
            end
        end
        stg2 <= stg[1];
    end

    assign rdata[0] = stg[0];
    assign rdata[1] = stg2;

    // Stream monitor: logs transfers and flags protocol violations seen at the falling edge.
    logic        mon_clr = 1'b0;
    int          pop_n [2];
    int          got_n [2];
    int          pop_empty_err [2];
    int          over_err [2];
    int          stall_err [2];
    int          done_n [2];
    int          outst [2];
    logic        prev_stall [2];
    logic [15:0] prev_data [2];
    logic [15:0] got_mem [2][512];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_clr) begin
                pop_n[i] <= 0; got_n[i] <= 0; pop_empty_err[i] <= 0; over_err[i] <= 0;
                stall_err[i] <= 0; done_n[i] <= 0; outst[i] <= 0; prev_stall[i] <= 1'b0;
                prev_data[i] <= '0;
            end else begin
                if (rd_en[i] === 1'b1) begin
                    pop_n[i] <= pop_n[i] + 1;
                    if (empty[i]) pop_empty_err[i] <= pop_empty_err[i] + 1;
                    if (outst[i] >= ((i == 0) ? 3 : 4)) over_err[i] <= over_err[i] + 1;
                end
                if (prev_stall[i] && (m_valid[i] !== 1'b1 || m_data[i] !== prev_data[i]))
                    stall_err[i] <= stall_err[i] + 1;
                if (m_valid[i] === 1'b1 && m_ready[i]) begin
                    got_mem[i][got_n[i]] <= m_data[i];
                    got_n[i] <= got_n[i] + 1;
                end
                if (done[i] === 1'b1) done_n[i] <= done_n[i] + 1;
                outst[i] <= outst[i] + ((rd_en[i] === 1'b1) ? 1 : 0)
                                     - ((m_valid[i] === 1'b1 && m_ready[i]) ? 1 : 0);
                prev_stall[i] <= (m_valid[i] === 1'b1) && !m_ready[i];
                prev_data[i]  <= m_data[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [15:0] w);
        fmem[i][fwr[i]] = w;
        fwr[i]++;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic wait_valid(input int i, input int limit, output int lat);
        lat = 0;
        @(negedge clk);
        while (m_valid[i] !== 1'b1 && lat < limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_idle_zero(input int i, input string tag);
        check($sformatf("%s_rd_en%0d", tag, i), 32'(rd_en[i]), 0);
        check($sformatf("%s_valid%0d", tag, i), 32'(m_valid[i]), 0);
        check($sformatf("%s_data%0d", tag, i), 32'(m_data[i]), 0);
        check($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 0);
        check($sformatf("%s_done%0d", tag, i), 32'(done[i]), 0);
        check($sformatf("%s_drop%0d", tag, i), drop[i], 0);
        check($sformatf("%s_err%0d", tag, i), 32'(err[i]), 0);
    endtask

    task automatic stream_check(input int i, input int base, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_valid_w%0d", tag, k), 32'(m_valid[i]), 1);
            check($sformatf("%s_data_w%0d", tag, k), 32'(m_data[i]), 32'(fmem[i][base + k]));
            @(negedge clk);
        end
    endtask

    task automatic score(input int i, input int base, input int n, input string tag);
        int mism;
        mism = 0;
        for (int k = 0; k < n; k++) if (got_mem[i][k] !== fmem[i][base + k]) mism++;
        check($sformatf("%s_count%0d", tag, i), 32'(got_n[i]), 32'(n));
        check($sformatf("%s_order%0d", tag, i), 32'(mism), 0);
        check($sformatf("%s_stall%0d", tag, i), 32'(stall_err[i]), 0);
        check($sformatf("%s_over%0d", tag, i), 32'(over_err[i]), 0);
        check($sformatf("%s_popempty%0d", tag, i), 32'(pop_empty_err[i]), 0);
    endtask

    initial begin
        int lat;
        int n;
        int base0;
        int base1;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2; i++) begin
            m_ready[i] = 1'b0; flush[i] = 1'b0; uf[i] = 1'b0;
        end

        // Reset state
        repeat (3) tick();
        check_idle_zero(0, "rst");
        check_idle_zero(1, "rst");
        rst = 1'b0;
        tick();
        clr_mon();

        // RD_LAT=1 stream of 0x0001..0x0008 with ready held high
        base0 = fwr[0];
        m_ready[0] = 1'b1;
        for (int k = 1; k <= 8; k++) push(0, 16'(k));
        wait_valid(0, 20, lat);
        check("s1_latency", 32'(lat), 2);
        stream_check(0, base0, 8, "s1");
        check("s1_valid_after", 32'(m_valid[0]), 0);
        repeat (3) tick();
        score(0, base0, 8, "s1");
        check("s1_err", 32'(err[0]), 0);

        // Same stream with ready toggling 1,0,0,1
        clr_mon();
        base0 = fwr[0];
        for (int k = 0; k < 8; k++) push(0, 16'($urandom));
        for (int c = 0; c < 40; c++) begin
            m_ready[0] = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
        end
        m_ready[0] = 1'b1;
        tick();
        score(0, base0, 8, "s2");

        // One word then empty
        clr_mon();
        base0 = fwr[0];
        push(0, 16'hA5A5);
        repeat (10) tick();
        check("s3_pops", 32'(pop_n[0]), 1);
        check("s3_got", 32'(got_n[0]), 1);
        check("s3_word", 32'(got_mem[0][0]), 32'h0000A5A5);
        check("s3_popempty", 32'(pop_empty_err[0]), 0);
        check("s3_err", 32'(err[0]), 0);

        // Flush with 10 words queued and the sink stalled
        clr_mon();
        m_ready[0] = 1'b0;
        base0 = fwr[0];
        for (int k = 0; k < 10; k++) push(0, 16'(16'h0100 + k));
        repeat (6) tick();
        check("s4_pre_valid", 32'(m_valid[0]), 1);
        check("s4_pre_data", 32'(m_data[0]), 32'(fmem[0][base0]));
        check("s4_pre_pops", 32'(pop_n[0]), 3);
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        check("s4_valid_in_flush", 32'(m_valid[0]), 0);
        check("s4_busy_in_flush", 32'(busy[0]), 1);
        n = 0;
        while (done[0] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("s4_done_seen", 32'(done[0]), 1);
        check("s4_drop", drop[0], 10);
        check("s4_busy_at_done", 32'(busy[0]), 0);
        tick();
        check("s4_done_pulse", 32'(done[0]), 0);
        repeat (3) tick();
        check("s4_done_count", 32'(done_n[0]), 1);
        check("s4_pops", 32'(pop_n[0]), 10);
        check("s4_no_output", 32'(got_n[0]), 0);

        // RD_LAT=2 continuous stream
        clr_mon();
        base1 = fwr[1];
        m_ready[1] = 1'b1;
        for (int k = 0; k < 12; k++) push(1, 16'($urandom));
        wait_valid(1, 20, lat);
        check("s5_latency", 32'(lat), 3);
        stream_check(1, base1, 12, "s5");
        repeat (3) tick();
        score(1, base1, 12, "s5");

        // Random traffic on both instances
        clr_mon();
        base0 = fwr[0];
        base1 = fwr[1];
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 1) == 1) push(i, 16'($urandom));
                m_ready[i] = ($urandom_range(0, 9) < 7);
            end
            tick();
        end
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        n = 0;
        while ((got_n[0] != fwr[0] - base0 || got_n[1] != fwr[1] - base1) && n < 500) begin
            tick();
            n++;
        end
        score(0, base0, fwr[0] - base0, "s6");
        score(1, base1, fwr[1] - base1, "s6");

        // Reset with words buffered and in flight
        clr_mon();
        m_ready[0] = 1'b0;
        m_ready[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(0, 16'(16'h0C00 + k));
            push(1, 16'(16'h0D00 + k));
        end
        repeat (3) tick();
        check("s7_pre_valid0", 32'(m_valid[0]), 1);
        check("s7_pre_busy1", 32'(busy[1]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero(0, "s7");
        check_idle_zero(1, "s7");
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        repeat (6) tick();
        check("s7_late_valid0", 32'(m_valid[0]), 0);
        check("s7_late_valid1", 32'(m_valid[1]), 0);
        check("s7_late_got1", 32'(got_n[1]), 0);
        check("s7_late_busy1", 32'(busy[1]), 0);

        // Sticky error on underflow
        uf[0] = 1'b1;
        tick();
        uf[0] = 1'b0;
        check("s8_err_set", 32'(err[0]), 1);
        check("s8_err_other", 32'(err[1]), 0);
        repeat (5) tick();
        check("s8_err_sticky", 32'(err[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s8_err_cleared", 32'(err[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

endmodule
